// File: rtl/riscv_mdu_pkg.sv
// Shared MDU definitions: funct3 operation codes, default XLEN and the FSM state type.
// The helpers decode each op's operand signedness in one place.
package riscv_mdu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] MDU_OP_REM    = 3'd6;
    localparam logic [2:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mdu_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

endpackage

// File: rtl/riscv_mdu_div.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle, XLEN cycles.
// o_done is high during the final iteration; quotient/remainder are valid the cycle after.
module riscv_mdu_div
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem,
    output logic            o_done
);

    localparam int CNT_W = $clog2(XLEN);

    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     dsr_q;
    logic [XLEN:0]       shift_w;
    logic [XLEN:0]       diff_w;

    // Partial remainder is XLEN+1 bits only while shifted; a restored value always fits XLEN.
    assign shift_w = {rem_q, quo_q[XLEN-1]};
    assign diff_w  = shift_w - {1'b0, dsr_q};
    assign o_done  = busy_q && (cnt_q == '0);
    assign o_quot  = quo_q;
    assign o_rem   = rem_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else if (i_start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(XLEN-1);
            rem_q  <= '0;
            quo_q  <= i_dividend;
            dsr_q  <= i_divisor;
        end else if (busy_q) begin
            if (diff_w[XLEN]) begin
                rem_q <= shift_w[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q <= diff_w[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_mdu.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Shift-add multiplier and sign-fix live here; division is delegated to riscv_mdu_div.
module riscv_mdu
    import riscv_mdu_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_div_zero
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   result_q;
    logic [2:0]        op_q;
    logic              neg_q, a_neg_q, div_zero_q;

    logic              a_neg, b_neg, accept, div_zero, ovf, fast, last, div_done;
    logic [XLEN-1:0]   mag_a, mag_b, fast_result, div_quot, div_rem, quot, rem, fix_result;
    logic [XLEN:0]     acc_sum;
    logic [2*XLEN-1:0] prod;

    assign a_neg    = op_a_signed(i_op) && i_a[XLEN-1];
    assign b_neg    = op_b_signed(i_op) && i_b[XLEN-1];
    assign mag_a    = a_neg ? -i_a : i_a;
    assign mag_b    = b_neg ? -i_b : i_b;
    assign accept   = (state_q == MDU_IDLE) && i_valid && !i_flush;
    assign div_zero = op_is_div(i_op) && (i_b == '0);
    assign ovf      = ((i_op == MDU_OP_DIV) || (i_op == MDU_OP_REM)) &&
                      (i_a == MIN_NEG) && (i_b == '1);
    assign fast     = div_zero || ovf;

    // i_op[1] separates REM/REMU from DIV/DIVU among the divide ops.
    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            fast_result = i_op[1] ? i_a : '1;
        end else if (ovf) begin
            fast_result = i_op[1] ? '0 : i_a;
        end
    end

    riscv_mdu_div #(.XLEN(XLEN)) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (accept && op_is_div(i_op) && !fast),
        .i_abort    (i_flush),
        .i_dividend (mag_a),
        .i_divisor  (mag_b),
        .o_quot     (div_quot),
        .o_rem      (div_rem),
        .o_done     (div_done)
    );

    assign acc_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign last    = op_is_div(op_q) ? div_done : (cnt_q == '0);
    assign prod    = neg_q ? -acc_q : acc_q;
    assign quot    = neg_q ? -div_quot : div_quot;
    assign rem     = a_neg_q ? -div_rem : div_rem;

    always_comb begin
        fix_result = '0;
        case (op_q)
            MDU_OP_MUL:                             fix_result = prod[XLEN-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            MDU_OP_DIV, MDU_OP_DIVU:                fix_result = quot;
            MDU_OP_REM, MDU_OP_REMU:                fix_result = rem;
            default:                                fix_result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept) state_d = fast ? MDU_DONE : MDU_CALC;
            MDU_CALC: if (i_flush) state_d = MDU_IDLE; else if (last) state_d = MDU_FIX;
            MDU_FIX:  state_d = i_flush ? MDU_IDLE : MDU_DONE;
            MDU_DONE: if (i_flush || i_ready) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= MDU_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            result_q   <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: if (accept) begin
                    op_q       <= i_op;
                    neg_q      <= a_neg ^ b_neg;
                    a_neg_q    <= a_neg;
                    mcand_q    <= mag_a;
                    acc_q      <= {{XLEN{1'b0}}, mag_b};
                    cnt_q      <= CNT_W'(XLEN-1);
                    div_zero_q <= div_zero;
                    if (fast) result_q <= fast_result;
                end
                MDU_CALC: if (!i_flush) begin
                    acc_q <= {acc_sum, acc_q[XLEN-1:1]};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                MDU_FIX: if (!i_flush) result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign o_ready    = (state_q == MDU_IDLE);
    assign o_valid    = (state_q == MDU_DONE);
    assign o_result   = result_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Self-checking bench for riscv_mdu (XLEN=32): directed cases, flush/reset aborts and
// randomized ops compared against a plain-arithmetic 64-bit reference model.
module tb_riscv_mdu;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_flush, i_ready;
    logic [2:0]  i_op;
    logic [31:0] i_a, i_b;
    logic        o_ready, o_valid, o_div_zero;
    logic [31:0] o_result;

    int n_cmp  = 0;
    int n_fail = 0;

    riscv_mdu #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_div_zero (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RISC-V M semantics from 64-bit integer arithmetic; only divide-by-zero is special.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_r, snap;
        logic        exp_dz, ready_bad, stable_bad;
        int          exp_lat, cyc;
        exp_r   = model(op, a, b);
        exp_dz  = op[2] && (b == 0);
        exp_lat = (exp_dz || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
        @(negedge i_clk);
        check("ready_idle", o_ready, 1);
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
        @(negedge i_clk);
        i_valid = 1'b0;
        cyc = 1;
        ready_bad = 1'b0;
        while (!o_valid && cyc < 200) begin
            if (o_ready) ready_bad = 1'b1;
            i_a = $urandom; i_b = $urandom; i_op = 3'($urandom);
            @(negedge i_clk);
            cyc++;
        end
        if (o_ready) ready_bad = 1'b1;
        check("valid_rise", o_valid, 1);
        check("latency", cyc, exp_lat);
        check("ready_busy", ready_bad, 0);
        check("result", o_result, exp_r);
        check("div_zero", o_div_zero, exp_dz);
        if (!o_valid) begin
            i_flush = 1'b1;
            @(negedge i_clk);
            i_flush = 1'b0;
            return;
        end
        snap = o_result;
        stable_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            if (!o_valid || o_result !== snap || o_div_zero !== exp_dz) stable_bad = 1'b1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("hs_ready", o_ready, 1);
        check("hs_valid", o_valid, 0);
        if (hold > 0) check("bp_stable", stable_bad, 0);
    endtask

    initial begin
        logic [31:0] snap, ra, rb;
        logic [2:0]  rop;
        logic        valid_seen;

        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op = '0; i_a = '0; i_b = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_dz", o_div_zero, 0);

        // Flush in IDLE must block an accept.
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_a = 32'd3; i_b = 32'd3;
        @(negedge i_clk);
        i_valid = 1'b0; i_flush = 1'b0;
        check("idle_flush_ready", o_ready, 1);
        check("idle_flush_valid", o_valid, 0);

        run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        0);
        run_op(3'd5, 32'd100,       32'd7,        0);
        run_op(3'd7, 32'd100,       32'd7,        5);
        run_op(3'd4, 32'd5,         32'd0,        5);
        run_op(3'd6, 32'd5,         32'd0,        0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'h1234_5678, 32'hDEAD_BEEF, 5);

        // Flush at cycle 10 of a DIVU.
        snap = o_result;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd5; i_a = 32'd1000; i_b = 32'd7;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_ready", o_ready, 1);
        check("flush_valid", o_valid, 0);
        check("flush_result", o_result, snap);
        valid_seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) valid_seen = 1'b1;
        end
        check("flush_no_valid", valid_seen, 0);
        run_op(3'd5, 32'd1000, 32'd7, 0);

        // Reset in the middle of CALC.
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd4; i_a = 32'hFFFF_0000; i_b = 32'd3;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_ready", o_ready, 1);
        check("midrst_valid", o_valid, 0);
        check("midrst_result", o_result, 0);
        check("midrst_dz", o_div_zero, 0);
        valid_seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) valid_seen = 1'b1;
        end
        check("midrst_no_valid", valid_seen, 0);
        run_op(3'd6, 32'hFFFF_0000, 32'd3, 0);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            run_op(rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
